// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip8_pkg
// Description : Shared definitions for the CHIP-8 8XYN ALU instruction path:
//               3-bit ALU operation codes (shared with the external ALU)
//               and the execution FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package chip8_pkg;

    // ALU operation codes, as seen on alu_op
    localparam logic [2:0] c_ALU_Y     = 3'd0;
    localparam logic [2:0] c_ALU_OR    = 3'd1;
    localparam logic [2:0] c_ALU_AND   = 3'd2;
    localparam logic [2:0] c_ALU_XOR   = 3'd3;
    localparam logic [2:0] c_ALU_PLUS  = 3'd4;
    localparam logic [2:0] c_ALU_MINUS = 3'd5;
    localparam logic [2:0] c_ALU_SHR   = 3'd6;
    localparam logic [2:0] c_ALU_SHL   = 3'd7;

    // Execution FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_Y = 3'd1,
        S_EXEC = 3'd2,
        S_WB_X = 3'd3,
        S_WB_F = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Bitwise ops produce no meaningful flag; their VF write (when enabled) is 0
    function automatic logic is_logic_op(input logic [2:0] op);
        return (op == c_ALU_OR) || (op == c_ALU_AND) || (op == c_ALU_XOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : chip8_alu_decode
// Description : Combinational decode of a CHIP-8 8XYN opcode into
//               {legal, alu_op, swap, writes_vf}.
//               Macro CHIP8_QUIRK_VF_RESET_EN: when defined, N=1,2,3 also
//               write VF (with 0).
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_alu_decode
    import chip8_pkg::*;
(
    input  logic [15:0] i_opcode,
    output logic        o_legal,
    output logic [2:0]  o_alu_op,
    output logic        o_swap,
    output logic        o_writes_vf
);

`ifdef CHIP8_QUIRK_VF_RESET_EN
    localparam logic c_LOGIC_WRITES_VF = 1'b1;
`else
    localparam logic c_LOGIC_WRITES_VF = 1'b0;
`endif

    // Map the N nibble to an ALU op; anything outside 8XY{0-7,E} is illegal
    always_comb begin
        o_legal     = 1'b0;
        o_alu_op    = c_ALU_Y;
        o_swap      = 1'b0;
        o_writes_vf = 1'b0;
        if (i_opcode[15:12] == 4'h8) begin
            case (i_opcode[3:0])
                4'h0: begin o_legal = 1'b1; o_alu_op = c_ALU_Y; end
                4'h1: begin o_legal = 1'b1; o_alu_op = c_ALU_OR;    o_writes_vf = c_LOGIC_WRITES_VF; end
                4'h2: begin o_legal = 1'b1; o_alu_op = c_ALU_AND;   o_writes_vf = c_LOGIC_WRITES_VF; end
                4'h3: begin o_legal = 1'b1; o_alu_op = c_ALU_XOR;   o_writes_vf = c_LOGIC_WRITES_VF; end
                4'h4: begin o_legal = 1'b1; o_alu_op = c_ALU_PLUS;  o_writes_vf = 1'b1; end
                4'h5: begin o_legal = 1'b1; o_alu_op = c_ALU_MINUS; o_writes_vf = 1'b1; end
                4'h6: begin o_legal = 1'b1; o_alu_op = c_ALU_SHR;   o_writes_vf = 1'b1; end
                4'h7: begin o_legal = 1'b1; o_alu_op = c_ALU_MINUS; o_writes_vf = 1'b1; o_swap = 1'b1; end
                4'hE: begin o_legal = 1'b1; o_alu_op = c_ALU_SHL;   o_writes_vf = 1'b1; end
                default: o_legal = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/chip8_alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : chip8_alu_exec
// Description : Sequencer for CHIP-8 8XYN instructions. Reads Vx and Vy from
//               an external register file (one-cycle read latency), drives an
//               external combinational ALU, writes Vx and optionally VF.
//               Macro CHIP8_QUIRK_VF_RESET_EN (via chip8_alu_decode): N=1,2,3
//               additionally clear VF.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_alu_exec
    import chip8_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        ready,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  reg_addr,
    input  logic [7:0]  reg_rdata,
    output logic        reg_we,
    output logic [7:0]  reg_wdata,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry
);

    state_t     r_state;
    logic       r_ready;
    logic       r_done;
    logic       r_illegal;
    logic       r_we;
    logic [7:0] r_wdata;
    logic [3:0] r_xsel;
    logic [3:0] r_ysel;
    logic [2:0] r_alu_op;
    logic       r_swap;
    logic       r_writes_vf;
    logic [7:0] r_vx;
    logic [7:0] r_op_x;
    logic [7:0] r_op_y;
    logic       r_carry;

    logic       w_legal;
    logic [2:0] w_alu_op;
    logic       w_swap;
    logic       w_writes_vf;
    logic [3:0] w_reg_addr;
    logic [7:0] w_alu_x;
    logic [7:0] w_alu_y;

    // Decode the incoming opcode so legality is known in the accept cycle
    chip8_alu_decode u_decode (
        .i_opcode    (opcode),
        .o_legal     (w_legal),
        .o_alu_op    (w_alu_op),
        .o_swap      (w_swap),
        .o_writes_vf (w_writes_vf)
    );

    // Register-file address: X is presented during accept so Vx arrives in RD_Y
    always_comb begin
        w_reg_addr = 4'h0;
        if (!reset) begin
            case (r_state)
                S_IDLE:         if (start) w_reg_addr = opcode[11:8];
                S_RD_Y, S_EXEC: w_reg_addr = r_ysel;
                S_WB_X:         w_reg_addr = r_xsel;
                S_WB_F:         w_reg_addr = 4'hF;
                default:        w_reg_addr = 4'h0;
            endcase
        end
    end

    // Operands go live in EXEC (Vy straight from the read port), held afterwards
    always_comb begin
        w_alu_x = r_op_x;
        w_alu_y = r_op_y;
        if (r_state == S_EXEC) begin
            if (r_swap) begin
                w_alu_x = reg_rdata;
                w_alu_y = r_vx;
            end else begin
                w_alu_x = r_vx;
                w_alu_y = reg_rdata;
            end
        end
    end

    // Instruction sequencer with registered handshake and write outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= 8'h00;
            r_xsel      <= 4'h0;
            r_ysel      <= 4'h0;
            r_alu_op    <= c_ALU_Y;
            r_swap      <= 1'b0;
            r_writes_vf <= 1'b0;
            r_vx        <= 8'h00;
            r_op_x      <= 8'h00;
            r_op_y      <= 8'h00;
            r_carry     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_we      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xsel  <= opcode[11:8];
                        r_ysel  <= opcode[7:4];
                        r_ready <= 1'b0;
                        if (w_legal) begin
                            r_alu_op    <= w_alu_op;
                            r_swap      <= w_swap;
                            r_writes_vf <= w_writes_vf;
                            r_state     <= S_RD_Y;
                        end else begin
                            r_done    <= 1'b1;
                            r_illegal <= 1'b1;
                            r_state   <= S_ERR;
                        end
                    end
                end
                S_RD_Y: begin
                    r_vx    <= reg_rdata;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_op_x  <= w_alu_x;
                    r_op_y  <= w_alu_y;
                    r_carry <= is_logic_op(r_alu_op) ? 1'b0 : alu_carry;
                    r_we    <= 1'b1;
                    r_wdata <= alu_out;
                    r_done  <= ~r_writes_vf;
                    r_state <= S_WB_X;
                end
                S_WB_X: begin
                    // VF goes last so the flag survives when X is F
                    if (r_writes_vf) begin
                        r_we    <= 1'b1;
                        r_wdata <= {7'b0, r_carry};
                        r_done  <= 1'b1;
                        r_state <= S_WB_F;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_WB_F: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset suppresses any write or completion already scheduled for this cycle
    assign ready     = r_ready;
    assign done      = r_done & ~reset;
    assign illegal   = r_illegal & ~reset;
    assign reg_we    = r_we & ~reset;
    assign reg_wdata = r_wdata;
    assign reg_addr  = w_reg_addr;
    assign alu_x     = w_alu_x;
    assign alu_y     = w_alu_y;
    assign alu_op    = r_alu_op;

endmodule
`default_nettype wire

// File: tb/tb_chip8_alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_alu_exec
// Description : Self-checking bench for chip8_alu_exec with a behavioural
//               register file and ALU; expected writes and completions are
//               queued at stimulus time and checked as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_alu_exec;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] opcode;
    logic        ready;
    logic        done;
    logic        illegal;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_rdata;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [2:0]  alu_op;
    logic [7:0]  alu_out;
    logic        alu_carry;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int done_count = 0;

    typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
    typedef struct { int cyc; logic ill; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    logic [7:0] regs [16];
    logic       pre_we;
    logic [3:0] pre_addr;
    logic [7:0] pre_data;

    chip8_alu_exec dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .ready     (ready),
        .done      (done),
        .illegal   (illegal),
        .reg_addr  (reg_addr),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: synchronous read, one-cycle latency; bench preload port
    always @(posedge clk) begin
        if (pre_we) regs[pre_addr] <= pre_data;
        else if (reg_we === 1'b1) regs[reg_addr] <= reg_wdata;
        reg_rdata <= regs[reg_addr];
    end

    // Reference ALU: MINUS flag is x > y
    always_comb begin
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        case (alu_op)
            3'd0: alu_out = alu_y;
            3'd1: alu_out = alu_x | alu_y;
            3'd2: alu_out = alu_x & alu_y;
            3'd3: alu_out = alu_x ^ alu_y;
            3'd4: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
            3'd5: begin alu_out = alu_x - alu_y; alu_carry = (alu_x > alu_y); end
            3'd6: begin alu_out = alu_x >> 1; alu_carry = alu_x[0]; end
            3'd7: begin alu_out = alu_x << 1; alu_carry = alu_x[7]; end
            default: alu_out = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard
    always @(negedge clk) begin
        if (reg_we === 1'b1) begin
            check("write_expected", (wq.size() > 0), 1);
            if (wq.size() > 0) begin
                wr_t w;
                w = wq.pop_front();
                check("write_addr", reg_addr, w.a);
                check("write_data", reg_wdata, w.d);
            end
        end
    end

    // Completion scoreboard
    always @(negedge clk) begin
        if (illegal === 1'b1 && done !== 1'b1) check("illegal_with_done", done, 1);
        if (done === 1'b1) begin
            done_count++;
            check("done_expected", (dq.size() > 0), 1);
            if (dq.size() > 0) begin
                dn_t e;
                e = dq.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_illegal", illegal, e.ill);
            end
        end
    end

    task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        wq.push_back(w);
    endtask

    // Issue one instruction; lat is the done cycle counted from accept
    task automatic run_op(input logic [15:0] op, input int lat, input logic ill, input bit poke);
        int  prev;
        dn_t e;
        @(posedge clk); #1;
        check("ready_before_start", ready, 1);
        start  = 1'b1;
        opcode = op;
        e.cyc  = cyc + lat;
        e.ill  = ill;
        dq.push_back(e);
        prev   = done_count;
        @(posedge clk); #1;
        start  = 1'b0;
        if (poke) begin
            @(posedge clk); #1;
            start  = 1'b1;
            opcode = 16'h8000;
            @(posedge clk); #1;
            start  = 1'b0;
        end
        for (int i = 0; i < 12; i++) begin
            if (done_count != prev) break;
            @(negedge clk); #1;
        end
        check("done_count", done_count - prev, 1);
        @(negedge clk);
        check("ready_after_done", ready, 1);
    endtask

    initial begin
        int dc;
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 16'h0000;
        pre_we = 1'b0;
        pre_addr = 4'h0;
        pre_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        check("rst_alu_x", alu_x, 0);
        check("rst_alu_y", alu_y, 0);
        check("rst_alu_op", alu_op, 0);

        // 8124: F0 + 20 -> 10, carry; busy start must be ignored
        set_reg(4'h1, 8'hF0);
        set_reg(4'h2, 8'h20);
        set_reg(4'hF, 8'h00);
        exp_wr(4'h1, 8'h10);
        exp_wr(4'hF, 8'h01);
        run_op(16'h8124, 4, 1'b0, 1'b1);
        check("add_v1", regs[1], 8'h10);
        check("add_vf", regs[15], 8'h01);
        check("hold_alu_op", alu_op, 4);
        check("hold_alu_x", alu_x, 8'hF0);
        check("hold_alu_y", alu_y, 8'h20);

        // 8120: V1 = V2, VF untouched
        exp_wr(4'h1, 8'h20);
        run_op(16'h8120, 3, 1'b0, 1'b0);
        check("mov_v1", regs[1], 8'h20);
        check("mov_vf", regs[15], 8'h01);

        // 8345: equal operands -> 0, flag 0
        set_reg(4'h3, 8'h05);
        set_reg(4'h4, 8'h05);
        exp_wr(4'h3, 8'h00);
        exp_wr(4'hF, 8'h00);
        run_op(16'h8345, 4, 1'b0, 1'b0);
        check("sub_v3", regs[3], 8'h00);
        check("sub_vf", regs[15], 8'h00);

        // 8347: V3 = V4 - V3 with swapped operands
        set_reg(4'h3, 8'h03);
        exp_wr(4'h3, 8'h02);
        exp_wr(4'hF, 8'h01);
        run_op(16'h8347, 4, 1'b0, 1'b0);
        check("subn_v3", regs[3], 8'h02);
        check("subn_vf", regs[15], 8'h01);
        check("subn_alu_x", alu_x, 8'h05);
        check("subn_alu_y", alu_y, 8'h03);

        // 8F06: X=F, flag write follows the result write
        set_reg(4'hF, 8'h81);
        set_reg(4'h0, 8'h33);
        exp_wr(4'hF, 8'h40);
        exp_wr(4'hF, 8'h01);
        run_op(16'h8F06, 4, 1'b0, 1'b0);
        check("shr_vf_final", regs[15], 8'h01);

        // 8121: OR, VF behaviour depends on the quirk
        set_reg(4'h1, 8'h0F);
        set_reg(4'h2, 8'h30);
        set_reg(4'hF, 8'h55);
        exp_wr(4'h1, 8'h3F);
`ifdef CHIP8_QUIRK_VF_RESET_EN
        exp_wr(4'hF, 8'h00);
        run_op(16'h8121, 4, 1'b0, 1'b0);
        check("or_vf", regs[15], 8'h00);
`else
        run_op(16'h8121, 3, 1'b0, 1'b0);
        check("or_vf", regs[15], 8'h55);
`endif
        check("or_v1", regs[1], 8'h3F);

        // 812E: SHL 81 -> 02, carry 1
        set_reg(4'h1, 8'h81);
        exp_wr(4'h1, 8'h02);
        exp_wr(4'hF, 8'h01);
        run_op(16'h812E, 4, 1'b0, 1'b0);
        check("shl_v1", regs[1], 8'h02);
        check("shl_vf", regs[15], 8'h01);

        // Illegal opcodes: done+illegal in cycle 1, no writes
        run_op(16'h8128, 1, 1'b1, 1'b0);
        run_op(16'h9120, 1, 1'b1, 1'b0);
        check("illegal_v1_kept", regs[1], 8'h02);

        // 8123 after illegal: XOR AA ^ FF -> 55
        set_reg(4'h1, 8'hAA);
        set_reg(4'h2, 8'hFF);
        exp_wr(4'h1, 8'h55);
`ifdef CHIP8_QUIRK_VF_RESET_EN
        exp_wr(4'hF, 8'h00);
        run_op(16'h8123, 4, 1'b0, 1'b0);
`else
        run_op(16'h8123, 3, 1'b0, 1'b0);
`endif
        check("xor_v1", regs[1], 8'h55);

        // Reset during EXEC aborts 8124
        set_reg(4'h1, 8'hF0);
        set_reg(4'h2, 8'h20);
        set_reg(4'hF, 8'h77);
        dc = done_count;
        @(posedge clk); #1;
        start  = 1'b1;
        opcode = 16'h8124;
        @(posedge clk); #1;
        start  = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        @(negedge clk);
        check("abort_ready", ready, 1);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_count, dc);
        check("abort_v1", regs[1], 8'hF0);
        check("abort_vf", regs[15], 8'h77);

        // Start coincident with reset is ignored
        @(posedge clk); #1;
        reset  = 1'b1;
        start  = 1'b1;
        opcode = 16'h8124;
        @(posedge clk); #1;
        reset  = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        check("rst_start_ready", ready, 1);
        repeat (5) @(negedge clk);
        check("rst_start_no_done", done_count, dc);
        check("rst_start_v1", regs[1], 8'hF0);

        check("write_queue_empty", wq.size(), 0);
        check("done_queue_empty", dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
